// File: rtl/pixel_stream_packer.sv
// Packs 24-bit RGB pixels into a 32-bit AXI4-Stream, 4 pixels per 3 words, with tlast/tuser framing.
// Define PIXEL_STREAM_PACKER_RGB_ORDER_EN to put r in the lowest byte (default order is b lowest).
module pixel_stream_packer (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        valid,
    input  logic        sof,
    input  logic        eol,
    output logic        in_stream_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_h;
    logic [23:0] r_held;
    logic        r_sof_latch;
    logic [31:0] r_tdata;
    logic [3:0]  r_tkeep;
    logic        r_tlast;
    logic        r_tuser;
    logic        r_tvalid;

    logic [7:0]  w_lane [3];
    logic [23:0] w_pix;
    logic        w_out_free;
    logic        w_accept;
    logic [1:0]  w_h_eff;
    logic        w_sof_now;
    logic        w_emit;
    logic [31:0] w_word;
    logic [3:0]  w_keep;
    logic [23:0] w_held_next;
    logic [1:0]  w_h_next;

`ifdef PIXEL_STREAM_PACKER_RGB_ORDER_EN
    assign w_lane[0] = r;
    assign w_lane[1] = g;
    assign w_lane[2] = b;
`else
    assign w_lane[0] = b;
    assign w_lane[1] = g;
    assign w_lane[2] = r;
`endif

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pix
            assign w_pix[gi*8 +: 8] = w_lane[gi];
        end
    endgenerate

    assign w_out_free = !r_tvalid || out_stream_tready;
    assign w_accept   = valid && in_stream_ready;
    // An sof pixel throws away any partial bytes of the previous line.
    assign w_h_eff    = sof ? 2'd0 : r_h;
    assign w_sof_now  = r_sof_latch || sof;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_accept && eol && w_h_eff[1]) w_state_next = FLUSH;
            FLUSH:   if (w_out_free) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_comb begin
        in_stream_ready = (r_state == RUN) && w_out_free;
    end

    // Byte packing for the pixel being accepted; eol only changes framing, not the remainder.
    always_comb begin
        w_emit      = 1'b1;
        w_word      = 32'd0;
        w_keep      = 4'hF;
        w_held_next = 24'd0;
        w_h_next    = 2'd0;
        case (w_h_eff)
            2'd0: begin
                if (eol) begin
                    w_word = {8'd0, w_pix};
                    w_keep = 4'b0111;
                end else begin
                    w_emit      = 1'b0;
                    w_keep      = 4'b0000;
                    w_held_next = w_pix;
                    w_h_next    = 2'd3;
                end
            end
            2'd3: begin
                w_word      = {w_pix[7:0], r_held};
                w_held_next = {8'd0, w_pix[23:8]};
                w_h_next    = 2'd2;
            end
            2'd2: begin
                w_word      = {w_pix[15:0], r_held[15:0]};
                w_held_next = {16'd0, w_pix[23:16]};
                w_h_next    = 2'd1;
            end
            default: begin
                w_word = {w_pix, r_held[7:0]};
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_h         <= 2'd0;
            r_held      <= 24'd0;
            r_sof_latch <= 1'b0;
            r_tdata     <= 32'd0;
            r_tkeep     <= 4'd0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_tvalid    <= 1'b0;
        end else if (r_state == FLUSH) begin
            // The eol remainder (1 or 2 bytes) follows once the first word leaves.
            if (w_out_free) begin
                r_tdata     <= {8'd0, r_held};
                r_tkeep     <= (r_h == 2'd2) ? 4'b0011 : 4'b0001;
                r_tlast     <= 1'b1;
                r_tuser     <= r_sof_latch;
                r_sof_latch <= 1'b0;
                r_tvalid    <= 1'b1;
                r_h         <= 2'd0;
                r_held      <= 24'd0;
            end
        end else if (w_accept) begin
            r_held <= w_held_next;
            r_h    <= w_h_next;
            if (w_emit) begin
                r_tdata     <= w_word;
                r_tkeep     <= w_keep;
                r_tlast     <= eol && !w_h_eff[1];
                r_tuser     <= w_sof_now;
                r_sof_latch <= 1'b0;
                r_tvalid    <= 1'b1;
            end else begin
                r_sof_latch <= w_sof_now;
                r_tvalid    <= 1'b0;
            end
        end else if (out_stream_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign out_stream_tdata  = r_tdata;
    assign out_stream_tkeep  = r_tkeep;
    assign out_stream_tlast  = r_tlast;
    assign out_stream_tuser  = r_tuser;
    assign out_stream_tvalid = r_tvalid;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer: byte-queue reference model, directed framing cases, random traffic.
module tb_pixel_stream_packer;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
    logic        valid = 1'b0, sof = 1'b0, eol = 1'b0;
    logic        in_stream_ready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tuser, tvalid;
    logic        tready = 1'b1;

    pixel_stream_packer dut (
        .aclk(aclk), .areset(areset), .r(r), .g(g), .b(b),
        .valid(valid), .sof(sof), .eol(eol),
        .in_stream_ready(in_stream_ready),
        .out_stream_tdata(tdata), .out_stream_tkeep(tkeep),
        .out_stream_tlast(tlast), .out_stream_tuser(tuser),
        .out_stream_tvalid(tvalid), .out_stream_tready(tready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } word_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    word_t  eq[$];
    word_t  got_q[$];
    logic [7:0] bq[$];
    bit     sof_pend = 0;
    bit     prev_stall = 0;
    word_t  prev_w;
    int     hs_count = 0;
    bit     watch_ready = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix_bytes(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
`ifdef PIXEL_STREAM_PACKER_RGB_ORDER_EN
        return {pb, pg, pr};
`else
        return {pr, pg, pb};
`endif
    endfunction

    // Line model: a byte FIFO cut into 4-byte words, eol flushes the rest as a short word.
    task automatic model_pixel(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                               input bit ps, input bit pe);
        word_t w;
        logic [23:0] pix;
        int n;
        pix = pix_bytes(pr, pg, pb);
        if (ps) begin
            bq.delete();
            sof_pend = 1;
        end
        for (int i = 0; i < 3; i++) bq.push_back(pix[i*8 +: 8]);
        while (bq.size() >= 4) begin
            w.d = {bq[3], bq[2], bq[1], bq[0]};
            repeat (4) void'(bq.pop_front());
            w.k = 4'hF;
            w.l = pe && (bq.size() == 0);
            w.u = sof_pend;
            sof_pend = 0;
            eq.push_back(w);
        end
        if (pe && bq.size() > 0) begin
            w.d = 32'd0;
            w.k = 4'd0;
            n = bq.size();
            for (int i = 0; i < n; i++) begin
                w.d[i*8 +: 8] = bq[i];
                w.k[i] = 1'b1;
            end
            bq.delete();
            w.l = 1'b1;
            w.u = sof_pend;
            sof_pend = 0;
            eq.push_back(w);
        end
    endtask

    always @(negedge aclk) begin
        word_t cur;
        word_t e;
        cur = {tdata, tkeep, tlast, tuser};
        if (areset) begin
            eq.delete();
            bq.delete();
            sof_pend = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_word", cur, prev_w);
                chk("hold_valid", tvalid, 1);
            end
            if (tvalid && tready) begin
                if (eq.size() == 0) begin
                    chk("expected_words_pending", eq.size(), 1);
                end else begin
                    e = eq.pop_front();
                    chk("word", cur, e);
                end
                got_q.push_back(cur);
                hs_count++;
            end
            if (valid && in_stream_ready) model_pixel(r, g, b, sof, eol);
            if (watch_ready && tready) chk("full_rate_ready", in_stream_ready, 1);
            prev_stall = tvalid && !tready;
            prev_w = cur;
        end
    end

    task automatic send(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                        input bit ps, input bit pe);
        int t;
        bit acc;
        t = 0;
        valid = 1'b1; r = pr; g = pg; b = pb; sof = ps; eol = pe;
        do begin
            @(negedge aclk);
            acc = in_stream_ready;
            @(posedge aclk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) chk("send_timeout", 0, 1);
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic check_known(input string tag, input int base);
        logic [31:0] exp_w [3];
`ifdef PIXEL_STREAM_PACKER_RGB_ORDER_EN
        exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605; exp_w[2] = 32'h0C0B0A09;
`else
        exp_w[0] = 32'h06010203; exp_w[1] = 32'h08090405; exp_w[2] = 32'h0A0B0C07;
`endif
        send(8'h01, 8'h02, 8'h03, 0, 0);
        send(8'h04, 8'h05, 8'h06, 0, 0);
        send(8'h07, 8'h08, 8'h09, 0, 0);
        send(8'h0A, 8'h0B, 8'h0C, 0, 0);
        idle(3);
        chk({tag, "_count"}, got_q.size() - base, 3);
        if (got_q.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) begin
                chk({tag, "_data"}, got_q[base+i].d, exp_w[i]);
                chk({tag, "_keep"}, got_q[base+i].k, 4'hF);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base, h0, users, lasts, lows;
        bit acc;
        logic [7:0] pr, pg, pb;

        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tkeep", tkeep, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tuser", tuser, 0);
        chk("rst_ready", in_stream_ready, 1);
        @(posedge aclk); #1;

        check_known("pack4", got_q.size());

        // Full 640-pixel line at full rate
        base = got_q.size();
        h0 = hs_count;
        watch_ready = 1;
        for (int i = 0; i < 640; i++)
            send($urandom, $urandom, $urandom, i == 0, i == 639);
        idle(3);
        watch_ready = 0;
        chk("line_words", hs_count - h0, 480);
        if (got_q.size() >= base + 480) begin
            users = 0; lasts = 0;
            for (int i = 0; i < 480; i++) begin
                users += got_q[base+i].u;
                lasts += got_q[base+i].l;
            end
            chk("line_users", users, 1);
            chk("line_lasts", lasts, 1);
            chk("line_first_user", got_q[base].u, 1);
            chk("line_last_tlast", got_q[base+479].l, 1);
        end

        // 2-pixel line then 1-pixel line
        base = got_q.size();
        send($urandom, $urandom, $urandom, 1, 0);
        send($urandom, $urandom, $urandom, 0, 1);
        valid = 1'b1; r = $urandom; g = $urandom; b = $urandom; sof = 1'b1; eol = 1'b1;
        lows = 0;
        do begin
            @(negedge aclk);
            acc = in_stream_ready;
            if (!acc) lows++;
            @(posedge aclk); #1;
        end while (!acc && lows < 50);
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
        chk("flush_ready_low", lows, 1);
        idle(4);
        chk("short_count", got_q.size() - base, 3);
        if (got_q.size() >= base + 3) begin
            chk("short_w0_keep", got_q[base].k, 4'hF);
            chk("short_w0_last", got_q[base].l, 0);
            chk("short_w1_keep", got_q[base+1].k, 4'b0011);
            chk("short_w1_last", got_q[base+1].l, 1);
            chk("short_w2_keep", got_q[base+2].k, 4'b0111);
            chk("short_w2_last", got_q[base+2].l, 1);
            chk("short_w2_user", got_q[base+2].u, 1);
        end

        // Output stall mid-line
        send($urandom, $urandom, $urandom, 1, 0);
        send($urandom, $urandom, $urandom, 0, 0);
        tready = 1'b0;
        pr = $urandom; pg = $urandom; pb = $urandom;
        valid = 1'b1; r = pr; g = pg; b = pb;
        repeat (10) begin
            @(negedge aclk);
            chk("stall_ready", in_stream_ready, 0);
            chk("stall_tvalid", tvalid, 1);
            @(posedge aclk); #1;
        end
        tready = 1'b1;
        send(pr, pg, pb, 0, 0);
        for (int i = 0; i < 3; i++)
            send($urandom, $urandom, $urandom, 0, i == 2);
        idle(4);

        // sof after 2 pixels discards the held bytes
        base = got_q.size();
        send($urandom, $urandom, $urandom, 0, 0);
        send($urandom, $urandom, $urandom, 0, 0);
        pr = $urandom; pg = $urandom; pb = $urandom;
        send(pr, pg, pb, 1, 0);
        send($urandom, $urandom, $urandom, 0, 0);
        idle(3);
        chk("sofmid_count", got_q.size() - base, 2);
        if (got_q.size() >= base + 2) begin
            chk("sofmid_w0_user", got_q[base].u, 0);
            chk("sofmid_w1_user", got_q[base+1].u, 1);
            chk("sofmid_w1_bytes", got_q[base+1].d[23:0], pix_bytes(pr, pg, pb));
        end
        send($urandom, $urandom, $urandom, 0, 1);
        idle(4);

        // Reset while FLUSH is pending
        send($urandom, $urandom, $urandom, 1, 0);
        tready = 1'b0;
        send($urandom, $urandom, $urandom, 0, 1);
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("flushrst_tvalid", tvalid, 0);
        chk("flushrst_ready", in_stream_ready, 1);
        @(posedge aclk); #1;
        tready = 1'b1;
        check_known("after_rst", got_q.size());

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            valid  = ($urandom_range(0, 9) < 7);
            r = $urandom; g = $urandom; b = $urandom;
            sof    = ($urandom_range(0, 49) == 0);
            eol    = ($urandom_range(0, 7) == 0);
            tready = ($urandom_range(0, 9) < 7);
            @(posedge aclk); #1;
        end
        valid = 1'b0; sof = 1'b0; eol = 1'b0; tready = 1'b1;
        idle(10);
        chk("drain_pending", eq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_stream_packer.md
PIXEL_STREAM_PACKER -- requirements
Module: pixel_stream_packer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all ports below are sampled or driven on the rising edge of aclk.
REQ-002 aclk  in  1  stream clock, the same clock as the pixel source.
REQ-003 areset  in  1  synchronous active-high reset.
REQ-004 r, g, b  in  8 each  pixel colour; the pixel is valid when valid=1.
REQ-005 valid  in  1  pixel present; sof  in  1  first pixel of frame; eol  in  1  last pixel of line.
REQ-006 in_stream_ready  out  1  the pixel is accepted when valid&in_stream_ready.
REQ-007 out_stream_tdata  out  32; out_stream_tkeep  out  4; out_stream_tlast  out  1; out_stream_tuser  out  1; out_stream_tvalid  out  1; out_stream_tready  in  1. These ports form an AXI4-Stream master.

Function
REQ-008 The block SHALL serialise each accepted pixel as 3 bytes in byte order b, g, r (b is the lowest byte), filling tdata from bits 7:0 upward, so that 4 pixels form 3 words.
REQ-009 The block SHALL keep a held-byte count h in {0,3,2,1}, which is h=(3*n) mod 4 after n pixels of the current line; the leftover bytes are held in a 24-bit register.
REQ-010 On acceptance, if h+3>=4 the block SHALL emit one full word (tkeep=1111), made of the held bytes in the low lanes followed by the new bytes; it SHALL hold the remainder and set h to h-1 (3->2->1->0).
REQ-011 On acceptance with h=0 and eol=0, the block SHALL emit no word and SHALL hold 3 bytes.
REQ-012 An eol pixel SHALL end the line as follows:
- h=1: one full word with tlast=1.
- h=0: one word with tkeep=0111 and tlast=1.
- h=3: a full word, then a word with tkeep=0011 and tlast=1.
- h=2: a full word, then a word with tkeep=0001 and tlast=1.
After the eol pixel, h SHALL return to 0.
REQ-013 Unused tdata lanes in a partial word SHALL be zero.
REQ-014 States SHALL be RUN and FLUSH. The block SHALL enter FLUSH when an eol pixel needs a second word. In FLUSH, in_stream_ready=0 and the second word is presented; the block SHALL return to RUN on the cycle that word handshakes.
REQ-015 There SHALL be a single output register. A word SHALL appear on the outputs the cycle after the accepting edge (latency 1).
REQ-016 While tvalid=1 and tready=0, tdata, tkeep, tlast and tuser SHALL be held stable.
REQ-017 In RUN, in_stream_ready SHALL equal !tvalid | tready.
REQ-018 sof SHALL be latched. tuser=1 SHALL mark the first word emitted after the sof pixel is accepted, including a partial word. The latch SHALL clear when that word handshakes.
REQ-019 An sof pixel accepted with h!=0 SHALL discard the held bytes without emitting them, SHALL restart at h=0, and then SHALL be processed as a normal pixel.
REQ-020 When valid=0 the state SHALL be unchanged, and a pending output word SHALL still drain.
REQ-021 A pixel that handshakes in the same cycle as an output word SHALL load the next word with no bubble, giving full throughput in RUN.

Reset
REQ-022 On areset=1 at a clock edge the block SHALL set:
- tvalid=0, tlast=0, tuser=0, tkeep=0000, tdata=0;
- h=0, state RUN, sof latch 0, held register 0.
REQ-023 in_stream_ready SHALL be 1 in the first cycle after reset is released.
REQ-024 A reset asserted mid-line or mid-FLUSH SHALL drop all held and pending data, and the block SHALL NOT emit a partial word.

Configuration
REQ-025 With macro PIXEL_STREAM_PACKER_RGB_ORDER_EN defined, the per-pixel byte order SHALL be r, g, b (r is the lowest byte). When the macro is undefined, the order SHALL be b, g, r as in REQ-008. All other behaviour SHALL be identical in both builds.

Verification
REQ-026 After reset, feed 4 pixels (r,g,b)=(01,02,03),(04,05,06),(07,08,09),(0A,0B,0C) with tready=1 -> the block emits 3 words 0x06010203, 0x08090405, 0x0A0B0C07, all with tkeep=1111 (default build).
REQ-027 Feed one 640-pixel line with sof on the first pixel and eol on the last -> the block emits 480 words; only word 0 has tuser=1; only word 479 has tlast=1; in_stream_ready is never low while tready=1.
REQ-028 Feed a 2-pixel line ending in eol -> the block emits a full word, then in_stream_ready=0 for 1 cycle, then a word with tkeep=0011 and tlast=1; a 1-pixel line emits a single word with tkeep=0111 and tlast=1.
REQ-029 Hold tready=0 for 10 cycles mid-line -> tdata, tkeep and tlast are held; in_stream_ready=0; no pixels are lost once tready returns to 1.
REQ-030 Assert sof after 2 pixels -> the block emits 1 full word, discards the held bytes, and the next word starts with the sof pixel's bytes and has tuser=1.
REQ-031 Assert areset in FLUSH -> the next cycle has tvalid=0 and in_stream_ready=1, and the next line packs from h=0.
